// File: rtl/dmem_seq.sv
// Data-memory access sequencer: takes one byte read/write request at a time,
// presents a direct address or enables a memory-resident pointer pair, then
// issues rd_latch/rd (read) or wr (write) strobes and finishes with an ack pulse.
module dmem_seq #(
  parameter int unsigned WAIT_STATES = 0,  // extra cycles per strobe phase, 0..7
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic              ind,
  input  logic [1:0]        ptr_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  inout  wire logic [ADDR_W-1:0] addbus,
  output logic [5:0]        point_add,
  inout  wire logic [7:0]   databus,
  output logic              rd_latch,
  output logic              rd,
  output logic              wr,
  output logic [7:0]        rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RDL   = 3'd2,
    RD    = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              we_q, ind_q, err_q;
  logic [1:0]        ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              addr_phase;
  logic              addr_drv;
  logic              data_drv;
  logic              accept;
  logic              illegal;

  assign accept  = (state == IDLE) && req;
  assign illegal = ind && (ptr_sel == 2'd3);

  // State register and wait-state counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; illegal pointer selection arms err for the DONE cycle
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      we_q    <= 1'b0;
      ind_q   <= 1'b0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= we;
      ind_q   <= ind;
      ptr_q   <= ptr_sel;
      addr_q  <= addr;
      wdata_q <= wdata;
      err_q   <= illegal;
    end
  end

  // Read data capture on the edge that ends the final RD cycle
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rdata <= '0;
    end else if ((state == RD) && (cnt == '0)) begin
      rdata <= databus;
    end
  end

  // Next-state, counter and Moore outputs decoded from the state register,
  // so an asynchronous reset drops every strobe and bus drive immediately
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rd_latch   = 1'b0;
    rd         = 1'b0;
    wr         = 1'b0;
    ack        = 1'b0;
    err        = 1'b0;
    busy       = 1'b1;
    addr_phase = 1'b0;
    data_drv   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) state_nxt = illegal ? DONE : SETUP;
      end
      SETUP: begin
        addr_phase = 1'b1;
        state_nxt  = we_q ? WR : RDL;
        cnt_nxt    = WS;
      end
      RDL: begin
        addr_phase = 1'b1;
        rd_latch   = 1'b1;
        if (cnt == '0) begin
          state_nxt = RD;
          cnt_nxt   = WS;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RD: begin
        addr_phase = 1'b1;
        rd         = 1'b1;
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 3'd1;
      end
      WR: begin
        addr_phase = 1'b1;
        wr         = 1'b1;
        data_drv   = 1'b1;
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 3'd1;
      end
      DONE: begin
        ack       = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address source: sequencer drives addbus directly, or the selected pointer
  // pair drives it through its output enables
  assign addr_drv  = addr_phase && !ind_q;
  assign point_add = (addr_phase && ind_q) ? (6'b000011 << {ptr_q, 1'b0}) : '0;

  assign addbus  = addr_drv ? addr_q  : 'z;
  assign databus = data_drv ? wdata_q : 'z;

endmodule

// File: tb/tb_dmem_seq.sv
// Directed bench for dmem_seq: a WAIT_STATES=0 instance attached to a small
// byte memory with pointer words, plus a WAIT_STATES=2 instance for timing.
module tb_dmem_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        req0, req1, we, ind;
  logic [1:0]  ptr_sel;
  logic [15:0] addr;
  logic [7:0]  wdata;

  wire  [15:0] addbus0, addbus1;
  wire  [7:0]  databus0, databus1;
  logic [5:0]  pa0, pa1;
  logic        rdl0, rd0, wr0, ack0, err0, busy0;
  logic        rdl1, rd1, wr1, ack1, err1, busy1;
  logic [7:0]  rdata0, rdata1;

  dmem_seq #(.WAIT_STATES(0), .ADDR_W(16)) u_dut0 (
    .clk(clk), .clr(clr), .req(req0), .we(we), .ind(ind), .ptr_sel(ptr_sel),
    .addr(addr), .wdata(wdata), .addbus(addbus0), .point_add(pa0),
    .databus(databus0), .rd_latch(rdl0), .rd(rd0), .wr(wr0), .rdata(rdata0),
    .ack(ack0), .err(err0), .busy(busy0)
  );

  dmem_seq #(.WAIT_STATES(2), .ADDR_W(16)) u_dut1 (
    .clk(clk), .clr(clr), .req(req1), .we(we), .ind(ind), .ptr_sel(ptr_sel),
    .addr(addr), .wdata(wdata), .addbus(addbus1), .point_add(pa1),
    .databus(databus1), .rd_latch(rdl1), .rd(rd1), .wr(wr1), .rdata(rdata1),
    .ack(ack1), .err(err1), .busy(busy1)
  );

  // Memory for instance 0; words 26..31 are pointer pairs (low byte first)
  logic [7:0]  mem [0:1023];
  logic [15:0] ptr_val;

  always_comb begin
    ptr_val = '0;
    for (int k = 0; k < 3; k++)
      if (pa0[2*k]) ptr_val = {mem[27+2*k], mem[26+2*k]};
  end

  assign addbus0  = (|pa0) ? ptr_val : 'z;
  assign databus0 = rd0 ? mem[addbus0[9:0]] : 'z;
  assign databus1 = rd1 ? 8'h5E : 'z;

  always @(posedge clk)
    if (wr0) mem[addbus0[9:0]] <= databus0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle traces: bit c = value in cycle c after the edge that sampled req
  logic [15:0] rdl_m, rd_m, wr_m, ack_m, err_m, busy_m, pa_m;
  logic [7:0]  db_c2;
  logic [15:0] ab_c2;
  logic [5:0]  pa_c2;

  task automatic run(input int inst, input logic w, input logic i,
                     input logic [1:0] p, input logic [15:0] a, input logic [7:0] d,
                     input int n, input int pulse, input logic hold);
    we = w; ind = i; ptr_sel = p; addr = a; wdata = d;
    if (inst == 0) req0 = 1'b1; else req1 = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
    rdl_m = '0; rd_m = '0; wr_m = '0; ack_m = '0; err_m = '0; busy_m = '0; pa_m = '0;
    for (int c = 1; c <= n; c++) begin
      rdl_m[c]  = (inst == 0) ? rdl0  : rdl1;
      rd_m[c]   = (inst == 0) ? rd0   : rd1;
      wr_m[c]   = (inst == 0) ? wr0   : wr1;
      ack_m[c]  = (inst == 0) ? ack0  : ack1;
      err_m[c]  = (inst == 0) ? err0  : err1;
      busy_m[c] = (inst == 0) ? busy0 : busy1;
      pa_m[c]   = (inst == 0) ? (|pa0) : (|pa1);
      if (c == 2) begin
        db_c2 = (inst == 0) ? databus0 : databus1;
        ab_c2 = addbus0;
        pa_c2 = pa0;
      end
      if (c == pulse) begin
        if (inst == 0) req0 = 1'b1; else req1 = 1'b1;
      end else if (!hold) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  logic [3:0] acks_after_rst;

  initial begin
    clr = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; ind = 1'b0;
    ptr_sel = '0; addr = '0; wdata = '0;
    #2;
    check("reset_ctrl", {busy0, ack0, err0, rdl0, rd0, wr0, pa0}, 32'h0);
    check("reset_rdata", rdata0, 32'h00);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;

    // Direct write 0x0005 <- 0xA7
    run(0, 1'b1, 1'b0, 2'd0, 16'h0005, 8'hA7, 6, 0, 1'b0);
    check("wr_strobe", wr_m, 16'h0004);
    check("wr_ack", ack_m, 16'h0008);
    check("wr_no_rd", rdl_m | rd_m | err_m, 16'h0000);
    check("wr_databus", db_c2, 32'hA7);
    check("wr_addbus", ab_c2, 32'h0005);

    // Direct read 0x0005
    run(0, 1'b0, 1'b0, 2'd0, 16'h0005, 8'h00, 6, 0, 1'b0);
    check("rd_latch", rdl_m, 16'h0004);
    check("rd_strobe", rd_m, 16'h0008);
    check("rd_ack", ack_m, 16'h0010);
    check("rd_busy", busy_m, 16'h001E);
    check("rd_data", rdata0, 32'hA7);

    // Preload pointers and targets through the sequencer
    run(0, 1'b1, 1'b0, 2'd0, 16'h001C, 8'h40, 4, 0, 1'b0);
    run(0, 1'b1, 1'b0, 2'd0, 16'h001D, 8'h00, 4, 0, 1'b0);
    run(0, 1'b1, 1'b0, 2'd0, 16'h0040, 8'h3C, 4, 0, 1'b0);
    run(0, 1'b1, 1'b0, 2'd0, 16'h001A, 8'h00, 4, 0, 1'b0);
    run(0, 1'b1, 1'b0, 2'd0, 16'h001B, 8'h01, 4, 0, 1'b0);
    run(0, 1'b1, 1'b0, 2'd0, 16'h0100, 8'h00, 4, 0, 1'b0);

    // Indirect read via words 28/29 (decoy direct address 0x0005)
    run(0, 1'b0, 1'b1, 2'd1, 16'h0005, 8'h00, 6, 0, 1'b0);
    check("ind_pa_cycles", pa_m, 16'h000E);
    check("ind_pa_bits", pa_c2, 32'h0C);
    check("ind_addbus", ab_c2, 32'h0040);
    check("ind_ack", ack_m, 16'h0010);
    check("ind_rdata", rdata0, 32'h3C);

    // Illegal pointer selection
    run(0, 1'b1, 1'b1, 2'd3, 16'h0005, 8'h55, 4, 0, 1'b0);
    check("ill_ack", ack_m, 16'h0002);
    check("ill_err", err_m, 16'h0002);
    check("ill_strobes", rdl_m | rd_m | wr_m | pa_m, 16'h0000);
    check("ill_busy", busy_m, 16'h0002);

    // Read with req pulsed again during RDL: no second transaction
    run(0, 1'b0, 1'b0, 2'd0, 16'h0005, 8'h00, 8, 2, 1'b0);
    check("repulse_ack", ack_m, 16'h0010);
    check("repulse_busy", busy_m, 16'h001E);
    check("repulse_rdata", rdata0, 32'hA7);

    // req held high: back-to-back writes, one IDLE cycle between
    run(0, 1'b1, 1'b0, 2'd0, 16'h0005, 8'hA7, 11, 0, 1'b1);
    check("held_wr", wr_m, 16'h0444);
    check("held_ack", ack_m, 16'h0888);
    check("held_busy", busy_m, 16'h0EEE);

    // WAIT_STATES = 2 read and write
    run(1, 1'b0, 1'b0, 2'd0, 16'h0123, 8'h00, 10, 0, 1'b0);
    check("ws2_rdl", rdl_m, 16'h001C);
    check("ws2_rd", rd_m, 16'h00E0);
    check("ws2_rd_ack", ack_m, 16'h0100);
    check("ws2_rdata", rdata1, 32'h5E);
    run(1, 1'b1, 1'b0, 2'd0, 16'h0123, 8'h11, 7, 0, 1'b0);
    check("ws2_wr", wr_m, 16'h001C);
    check("ws2_wr_ack", ack_m, 16'h0020);

    // Reset asserted during an indirect WR through words 26/27 (-> 0x0100)
    we = 1'b1; ind = 1'b1; ptr_sel = 2'd0; addr = 16'h0005; wdata = 8'h99;
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_wr", {wr0, |pa0}, 32'h3);
    clr = 1'b0;
    #1;
    check("rst_drop", {wr0, busy0, pa0}, 32'h0);
    @(posedge clk); #1;
    clr = 1'b1;
    acks_after_rst = '0;
    for (int c = 0; c < 4; c++) begin
      acks_after_rst[c] = ack0;
      @(posedge clk); #1;
    end
    check("rst_no_ack", acks_after_rst, 32'h0);
    check("rst_rdata", rdata0, 32'h00);
    check("rst_idle", busy0, 32'h0);

    // Abandoned write must not have reached memory
    run(0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h00, 6, 0, 1'b0);
    check("rst_no_write", rdata0, 32'h00);
    check("rst_rd_ack", ack_m, 16'h0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
